rfc2819_stat_unit: RTL

Parametrised RFC2819 statistics block for the RX MAC Lite datapath.
- Accepts up to REGIONS frame-end events per cycle and classifies each frame by length, error and address type.
- Accumulates classifications into CNT_WIDTH-bit wrapping counters.
- On command, copies all counters atomically into shadow registers; software reads the shadows as 32-bit low/high words on a simple read port.
- Replaces the single-frame-per-cycle counter logic; sits between the RX MAC Lite checker and its MI decoder.

---
 rtl/rfc2819_stat_pkg.sv | 44 ++++
 rtl/rfc2819_stat_classify.sv | 43 ++++
 rtl/rfc2819_stat_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rfc2819_stat_pkg.sv
// rtl/rfc2819_stat_pkg.sv - counter indices, address map and RFC2819 length bins (RFC2819_STAT_EXTENDED_EN adds over/under bins)
package rfc2819_stat_pkg;

  localparam int NUM_BASE_CNT = 14;
  localparam int NUM_EXT_CNT  = 2;

`ifdef RFC2819_STAT_EXTENDED_EN
  localparam int NUM_CNT = NUM_BASE_CNT + NUM_EXT_CNT;
`else
  localparam int NUM_CNT = NUM_BASE_CNT;
`endif

  // Counter index doubles as the flag bit position and the word offset in the read map
  typedef enum logic [3:0] {
    CNT_CRC           = 4'd0,
    CNT_MTU           = 4'd1,
    CNT_MINTU         = 4'd2,
    CNT_BCAST         = 4'd3,
    CNT_MCAST         = 4'd4,
    CNT_FRAGMENT      = 4'd5,
    CNT_JABBER        = 4'd6,
    CNT_OCTETS        = 4'd7,
    CNT_BIN_64        = 4'd8,
    CNT_BIN_65_127    = 4'd9,
    CNT_BIN_128_255   = 4'd10,
    CNT_BIN_256_511   = 4'd11,
    CNT_BIN_512_1023  = 4'd12,
    CNT_BIN_1024_1518 = 4'd13,
    CNT_BIN_OVER      = 4'd14,
    CNT_BIN_UNDER     = 4'd15
  } cnt_idx_e;

  localparam logic [7:0] ADDR_LOW_BASE  = 8'h00;
  localparam logic [7:0] ADDR_HIGH_BASE = 8'h38;
  localparam logic [7:0] ADDR_EXT_BASE  = 8'h70;

  localparam int unsigned LEN_BIN_64   = 64;
  localparam int unsigned LEN_BIN_127  = 127;
  localparam int unsigned LEN_BIN_255  = 255;
  localparam int unsigned LEN_BIN_511  = 511;
  localparam int unsigned LEN_BIN_1023 = 1023;
  localparam int unsigned LEN_BIN_1518 = 1518;

endpackage

// File: rtl/rfc2819_stat_classify.sv
// rtl/rfc2819_stat_classify.sv - per-region frame classification into a counter flag vector (RFC2819_STAT_EXTENDED_EN adds over/under bins)
module rfc2819_stat_classify
  import rfc2819_stat_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 vld,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 crc_err,
  input  logic                 bcast,
  input  logic                 mcast,
  input  logic [LEN_WIDTH-1:0] len_max,
  input  logic [LEN_WIDTH-1:0] len_min,
  output logic [NUM_CNT-1:0]   flags
);

  logic [31:0] len32;
  assign len32 = 32'(len);

  // Every flag is qualified by vld; the octets bit carries vld itself so stage 2 knows which lengths to sum
  always_comb begin
    flags                    = '0;
    flags[CNT_CRC]           = vld & crc_err;
    flags[CNT_MTU]           = vld & (len > len_max);
    flags[CNT_MINTU]         = vld & (len < len_min);
    flags[CNT_BCAST]         = vld & bcast;
    flags[CNT_MCAST]         = vld & mcast;
    flags[CNT_FRAGMENT]      = vld & crc_err & (len32 < LEN_BIN_64);
    flags[CNT_JABBER]        = vld & crc_err & (len32 > LEN_BIN_1518);
    flags[CNT_OCTETS]        = vld;
    flags[CNT_BIN_64]        = vld & (len32 == LEN_BIN_64);
    flags[CNT_BIN_65_127]    = vld & (len32 > LEN_BIN_64)   & (len32 <= LEN_BIN_127);
    flags[CNT_BIN_128_255]   = vld & (len32 > LEN_BIN_127)  & (len32 <= LEN_BIN_255);
    flags[CNT_BIN_256_511]   = vld & (len32 > LEN_BIN_255)  & (len32 <= LEN_BIN_511);
    flags[CNT_BIN_512_1023]  = vld & (len32 > LEN_BIN_511)  & (len32 <= LEN_BIN_1023);
    flags[CNT_BIN_1024_1518] = vld & (len32 > LEN_BIN_1023) & (len32 <= LEN_BIN_1518);
`ifdef RFC2819_STAT_EXTENDED_EN
    flags[CNT_BIN_OVER]      = vld & (len32 > LEN_BIN_1518);
    flags[CNT_BIN_UNDER]     = vld & (len32 < LEN_BIN_64);
`endif
  end

endmodule

// File: rtl/rfc2819_stat_unit.sv
// rtl/rfc2819_stat_unit.sv - multi-region RFC2819 statistics counters with atomic shadow snapshot and read port (RFC2819_STAT_EXTENDED_EN adds over/under bins)
module rfc2819_stat_unit
  import rfc2819_stat_pkg::*;
#(
  parameter int REGIONS   = 4,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 64
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [REGIONS-1:0]             RX_EOF_VLD,
  input  logic [REGIONS*LEN_WIDTH-1:0]   RX_LEN,
  input  logic [REGIONS-1:0]             RX_CRC_ERR,
  input  logic [REGIONS-1:0]             RX_BCAST,
  input  logic [REGIONS-1:0]             RX_MCAST,
  input  logic [LEN_WIDTH-1:0]           CFG_LEN_MAX,
  input  logic [LEN_WIDTH-1:0]           CFG_LEN_MIN,
  input  logic                           CMD_SNAPSHOT,
  input  logic                           CMD_CLEAR,
  input  logic                           RD_EN,
  input  logic [7:0]                     RD_ADDR,
  output logic [31:0]                    RD_DATA,
  output logic                           RD_VLD
);

  localparam int PCW   = $clog2(REGIONS + 1);
  localparam int OCT_W = LEN_WIDTH + PCW;

  logic [NUM_CNT-1:0]   s0_flags [REGIONS];
  logic [NUM_CNT-1:0]   s1_flags [REGIONS];
  logic [LEN_WIDTH-1:0] s1_len   [REGIONS];
  logic [CNT_WIDTH-1:0] inc      [NUM_CNT];
  logic [CNT_WIDTH-1:0] live     [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow   [NUM_CNT];
  logic [PCW-1:0]       pc_acc;
  logic [OCT_W-1:0]     oct_acc;
  logic [31:0]          rd_word;

  function automatic logic [31:0] word_sel(input logic [CNT_WIDTH-1:0] v, input logic hi);
    logic [63:0] v64;
    v64 = 64'(v);
    return hi ? v64[63:32] : v64[31:0];
  endfunction

  for (genvar r = 0; r < REGIONS; r++) begin : g_region
    rfc2819_stat_classify #(
      .LEN_WIDTH (LEN_WIDTH)
    ) u_classify (
      .vld     (RX_EOF_VLD[r]),
      .len     (RX_LEN[r*LEN_WIDTH +: LEN_WIDTH]),
      .crc_err (RX_CRC_ERR[r]),
      .bcast   (RX_BCAST[r]),
      .mcast   (RX_MCAST[r]),
      .len_max (CFG_LEN_MAX),
      .len_min (CFG_LEN_MIN),
      .flags   (s0_flags[r])
    );
  end

  // Stage 1: register the classified flags and raw lengths; flags of invalid regions are already zero
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < REGIONS; i++) begin
        s1_flags[i] <= '0;
        s1_len[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < REGIONS; i++) begin
        s1_flags[i] <= s0_flags[i];
        s1_len[i]   <= RX_LEN[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Stage 2 increments: popcount of each flag across regions; octets sums the valid lengths instead
  always_comb begin
    pc_acc  = '0;
    oct_acc = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      pc_acc = '0;
      for (int i = 0; i < REGIONS; i++) begin
        pc_acc = pc_acc + PCW'(s1_flags[i][c]);
      end
      inc[c] = CNT_WIDTH'(pc_acc);
    end
    for (int i = 0; i < REGIONS; i++) begin
      if (s1_flags[i][CNT_OCTETS]) begin
        oct_acc = oct_acc + OCT_W'(s1_len[i]);
      end
    end
    inc[CNT_OCTETS] = CNT_WIDTH'(oct_acc);
  end

  // Live counters wrap freely; a clear keeps only the increment landing on the same edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < NUM_CNT; c++) begin
        live[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CNT; c++) begin
        live[c] <= CMD_CLEAR ? inc[c] : live[c] + inc[c];
      end
    end
  end

  // Shadows copy the pre-update live values, so a concurrent clear never leaks into the snapshot
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < NUM_CNT; c++) begin
        shadow[c] <= '0;
      end
    end else if (CMD_SNAPSHOT) begin
      for (int c = 0; c < NUM_CNT; c++) begin
        shadow[c] <= live[c];
      end
    end
  end

  // Address decode over the shadows; anything not matched reads as zero
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_BASE_CNT; c++) begin
      if (RD_ADDR == ADDR_LOW_BASE + 8'(4 * c)) begin
        rd_word = word_sel(shadow[c], 1'b0);
      end
      if (RD_ADDR == ADDR_HIGH_BASE + 8'(4 * c)) begin
        rd_word = word_sel(shadow[c], 1'b1);
      end
    end
`ifdef RFC2819_STAT_EXTENDED_EN
    for (int e = 0; e < NUM_EXT_CNT; e++) begin
      if (RD_ADDR == ADDR_EXT_BASE + 8'(8 * e)) begin
        rd_word = word_sel(shadow[NUM_BASE_CNT + e], 1'b0);
      end
      if (RD_ADDR == ADDR_EXT_BASE + 8'(8 * e + 4)) begin
        rd_word = word_sel(shadow[NUM_BASE_CNT + e], 1'b1);
      end
    end
`endif
  end

  // One-cycle read response; data is held at zero when no read is pending
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RD_VLD  <= 1'b0;
      RD_DATA <= '0;
    end else begin
      RD_VLD  <= RD_EN;
      RD_DATA <= RD_EN ? rd_word : 32'd0;
    end
  end

endmodule
